multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit_pkg.sv | 43 ++++
 rtl/multicycle_control_unit_alu_decoder.sv | 30 +++
 rtl/multicycle_control_unit.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and encodings for the multicycle RV32 control unit:
// FSM states, opcode constants, ALUControl and ImmSrc encodings.
package multicycle_control_unit_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC, S_MDUWAIT, S_ILLEGAL
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000, ALU_SUB  = 4'b0001, ALU_AND = 4'b0010, ALU_OR  = 4'b0011,
    ALU_XOR  = 4'b0100, ALU_SLT  = 4'b0101, ALU_SLTU = 4'b0110, ALU_SLL = 4'b0111,
    ALU_SRL  = 4'b1000, ALU_SRA  = 4'b1001
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100
  } imm_e;

  // Immediate format is a pure function of the opcode; R-type and unknown ops fall back to I.
  function automatic imm_e imm_for_op(input logic [6:0] op);
    case (op)
      OP_STORE:          return IMM_S;
      OP_BRANCH:         return IMM_B;
      OP_JAL:            return IMM_J;
      OP_LUI, OP_AUIPC:  return IMM_U;
      default:           return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational funct3/funct7/opcode to ALUControl decode for the execute states.
module mc_alu_decoder
  import multicycle_control_unit_pkg::*;
(
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  output alu_op_e    o_alu_ctrl
);

  logic w_rtype;
  assign w_rtype = (i_op == OP_RTYPE);

  // funct7[5] on an I-type ADDI is an immediate bit, so SUB needs the R-type qualifier.
  always_comb begin
    o_alu_ctrl = ALU_ADD;
    case (i_funct3)
      3'b000:  o_alu_ctrl = (w_rtype && i_funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  o_alu_ctrl = ALU_SLL;
      3'b010:  o_alu_ctrl = ALU_SLT;
      3'b011:  o_alu_ctrl = ALU_SLTU;
      3'b100:  o_alu_ctrl = ALU_XOR;
      3'b101:  o_alu_ctrl = i_funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  o_alu_ctrl = ALU_OR;
      3'b111:  o_alu_ctrl = ALU_AND;
      default: o_alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I(+M) main control FSM with memory/MDU handshakes.
// ALUSrcA: 00 PC, 01 OldPC, 10 rs1, 11 zero.  ALUSrcB: 00 rs2, 01 imm, 10 const 4.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int M_EXT  = 1,
  parameter int IMM_W  = 3,
  parameter int ALUC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        Op,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic              Taken,
  input  logic              mem_ready,
  input  logic              mdu_done,
  output logic              mem_req,
  output logic              PCWrite,
  output logic              IRWrite,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic              AdrSrc,
  output logic [1:0]        ResultSrc,
  output logic [1:0]        ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [IMM_W-1:0]  ImmSrc,
  output logic [ALUC_W-1:0] ALUControl,
  output logic              mdu_start,
  output logic              illegal
);

  state_e     r_state;
  state_e     w_next;
  logic       r_mdu_busy;
  alu_op_e    w_alu_funct;
  logic [3:0] w_alu_sel;
  logic       w_muldiv;

  mc_alu_decoder u_alu_dec (
    .i_op       (Op),
    .i_funct3   (funct3),
    .i_funct7_5 (funct7[5]),
    .o_alu_ctrl (w_alu_funct)
  );

  assign w_muldiv   = (funct7 == F7_MULDIV);
  assign ImmSrc     = IMM_W'(imm_for_op(Op));
  assign ALUControl = ALUC_W'(w_alu_sel);

  // r_mdu_busy marks MDUWAIT cycles after the first, so mdu_start is a single pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_FETCH;
      r_mdu_busy <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_mdu_busy <= (r_state == S_MDUWAIT) && !mdu_done;
    end
  end

  always_comb begin
    w_next    = r_state;
    mem_req   = 1'b0;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    w_alu_sel = ALU_ADD;
    mdu_start = 1'b0;
    illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (Op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE: begin
            if (!w_muldiv)        w_next = S_EXECR;
            else if (M_EXT != 0)  w_next = S_MDUWAIT;
            else                  w_next = S_ILLEGAL;
          end
          OP_ITYPE:  w_next = S_EXECI;
          OP_BRANCH: w_next = S_BRANCH;
          OP_JAL:    w_next = S_JAL;
          OP_JALR:   w_next = S_JALR;
          OP_LUI:    w_next = S_LUI;
          OP_AUIPC:  w_next = S_AUIPC;
          default:   w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        w_next  = (Op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite  = 1'b1;
        ResultSrc = 2'b01;
        w_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA   = 2'b10;
        w_alu_sel = w_alu_funct;
        w_next    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        w_alu_sel = w_alu_funct;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA   = 2'b10;
        w_alu_sel = ALU_SUB;
        PCWrite   = Taken;
        w_next    = S_FETCH;
      end
      // PC takes the DECODE-computed target from ALUOut while the ALU forms OldPC+4 for rd.
      S_JAL: begin
        PCWrite = 1'b1;
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        w_next  = S_ALUWB;
      end
      S_JALR: begin
        PCWrite   = 1'b1;
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        w_next    = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        w_next  = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        w_next  = S_ALUWB;
      end
      S_MDUWAIT: begin
        mdu_start = !r_mdu_busy;
        if (mdu_done) w_next = S_ALUWB;
      end
      S_ILLEGAL: illegal = 1'b1;
    endcase
    // Reset forces quiet outputs immediately, without waiting for a clock edge.
    if (!rst) begin
      mem_req   = 1'b0;
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      MemWrite  = 1'b0;
      AdrSrc    = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      w_alu_sel = ALU_ADD;
      mdu_start = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboarded cycle-by-cycle bench for the multicycle control unit (M_EXT=1 and M_EXT=0 instances).
module tb_multicycle_control_unit;

  typedef logic [20:0] vec_t;
  typedef struct { logic rdy; logic done; logic tk; vec_t exp; } cyc_t;

  logic clk = 1'b0;
  logic rst;
  logic [6:0] Op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic Taken, mem_ready, mdu_done;

  logic mem_req, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, mdu_start, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;

  logic n_mem_req, n_PCWrite, n_IRWrite, n_RegWrite, n_MemWrite, n_AdrSrc, n_mdu_start, n_illegal;
  logic [1:0] n_ResultSrc, n_ALUSrcA, n_ALUSrcB;
  logic [2:0] n_ImmSrc;
  logic [3:0] n_ALUControl;

  vec_t w_obs, w_obs0;
  cyc_t sb[$];
  cyc_t c;
  int vectors = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.M_EXT(1), .IMM_W(3), .ALUC_W(4)) dut (
    .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7), .Taken(Taken),
    .mem_ready(mem_ready), .mdu_done(mdu_done), .mem_req(mem_req), .PCWrite(PCWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .mdu_start(mdu_start), .illegal(illegal)
  );

  multicycle_control_unit #(.M_EXT(0), .IMM_W(3), .ALUC_W(4)) dut0 (
    .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7), .Taken(Taken),
    .mem_ready(mem_ready), .mdu_done(mdu_done), .mem_req(n_mem_req), .PCWrite(n_PCWrite),
    .IRWrite(n_IRWrite), .RegWrite(n_RegWrite), .MemWrite(n_MemWrite), .AdrSrc(n_AdrSrc),
    .ResultSrc(n_ResultSrc), .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB), .ImmSrc(n_ImmSrc),
    .ALUControl(n_ALUControl), .mdu_start(n_mdu_start), .illegal(n_illegal)
  );

  assign w_obs  = {illegal, mdu_start, mem_req, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
                   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};
  assign w_obs0 = {n_illegal, n_mdu_start, n_mem_req, n_PCWrite, n_IRWrite, n_RegWrite,
                   n_MemWrite, n_AdrSrc, n_ResultSrc, n_ALUSrcA, n_ALUSrcB, n_ImmSrc, n_ALUControl};

  // Expected output word: {illegal, mdu_start, mem_req, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl}
  function automatic vec_t e(input logic il, st, mr, pcw, irw, rw, mw, adr,
                             input logic [1:0] rs, a, b, input logic [2:0] imm, input logic [3:0] alu);
    return {il, st, mr, pcw, irw, rw, mw, adr, rs, a, b, imm, alu};
  endfunction
  function automatic vec_t x_fetch(input logic rdy, input logic [2:0] imm);
    return e(0, 0, 1, rdy, rdy, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm, 4'h0);
  endfunction
  function automatic vec_t x_decode(input logic [2:0] imm);
    return e(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 4'h0);
  endfunction
  function automatic vec_t x_aluwb(input logic [2:0] imm);
    return e(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, imm, 4'h0);
  endfunction
  function automatic vec_t x_quiet(input logic [2:0] imm);
    return e(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 4'h0);
  endfunction

  task automatic push(input logic rdy, input logic done, input logic tk, input vec_t exp);
    cyc_t n;
    n.rdy = rdy; n.done = done; n.tk = tk; n.exp = exp;
    sb.push_back(n);
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    Op = op; funct3 = f3; funct7 = f7;
  endtask

  task automatic test_reset;
    rst = 1'b0; mem_ready = 1'b0; mdu_done = 1'b0; Taken = 1'b0;
    set_instr(7'b0110011, 3'b000, 7'b0000000);
    repeat (2) @(negedge clk);
    vectors++;
    if (w_obs !== x_quiet(3'b000)) begin
      fails++; $display("FAIL reset_outputs got=%h want=%h", w_obs, x_quiet(3'b000));
    end
    vectors++;
    if (w_obs0 !== x_quiet(3'b000)) begin
      fails++; $display("FAIL reset_outputs_m0 got=%h want=%h", w_obs0, x_quiet(3'b000));
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (w_obs !== x_fetch(1'b0, 3'b000)) begin
      fails++; $display("FAIL reset_release got=%h want=%h", w_obs, x_fetch(1'b0, 3'b000));
    end
  endtask

  task automatic test_add;
    int n = 0;
    set_instr(7'b0110011, 3'b000, 7'b0000000);
    push(1, 0, 0, x_fetch(1, 3'b000));
    push(1, 0, 0, x_decode(3'b000));
    push(1, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 4'h0));
    push(1, 0, 0, x_aluwb(3'b000));
    push(0, 0, 0, x_fetch(0, 3'b000));
    while (sb.size() != 0) begin
      c = sb[0];
      @(posedge clk); #1;
      mem_ready = c.rdy; mdu_done = c.done; Taken = c.tk;
      @(negedge clk);
      c = sb.pop_front(); vectors++;
      if (w_obs !== c.exp) begin fails++; $display("FAIL add cyc%0d got=%h want=%h", n, w_obs, c.exp); end
      n++;
    end
  endtask

  task automatic test_alu_ops;
    logic [6:0] ops [5] = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011};
    logic [2:0] f3s [5] = '{3'b000, 3'b101, 3'b100, 3'b101, 3'b000};
    logic [3:0] alus[5] = '{4'b0001, 4'b1001, 4'b0100, 4'b1001, 4'b0000};
    for (int k = 0; k < 5; k++) begin
      int n = 0;
      set_instr(ops[k], f3s[k], 7'b0100000);
      push(1, 0, 0, x_fetch(1, 3'b000));
      push(1, 0, 0, x_decode(3'b000));
      push(1, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, (ops[k] == 7'b0010011) ? 2'b01 : 2'b00,
                      3'b000, alus[k]));
      push(1, 0, 0, x_aluwb(3'b000));
      push(0, 0, 0, x_fetch(0, 3'b000));
      while (sb.size() != 0) begin
        c = sb[0];
        @(posedge clk); #1;
        mem_ready = c.rdy; mdu_done = c.done; Taken = c.tk;
        @(negedge clk);
        c = sb.pop_front(); vectors++;
        if (w_obs !== c.exp) begin fails++; $display("FAIL alu_op%0d cyc%0d got=%h want=%h", k, n, w_obs, c.exp); end
        n++;
      end
    end
  endtask

  task automatic test_load_wait;
    int n = 0;
    set_instr(7'b0000011, 3'b010, 7'b0000000);
    push(1, 0, 0, x_fetch(1, 3'b000));
    push(0, 0, 0, x_decode(3'b000));
    push(0, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 4'h0));
    for (int i = 0; i < 4; i++)
      push(i == 3, 0, 0, e(0, 0, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0));
    push(0, 0, 0, e(0, 0, 0, 0, 0, 1, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 4'h0));
    push(0, 0, 0, x_fetch(0, 3'b000));
    while (sb.size() != 0) begin
      c = sb[0];
      @(posedge clk); #1;
      mem_ready = c.rdy; mdu_done = c.done; Taken = c.tk;
      @(negedge clk);
      c = sb.pop_front(); vectors++;
      if (w_obs !== c.exp) begin fails++; $display("FAIL lw cyc%0d got=%h want=%h", n, w_obs, c.exp); end
      n++;
    end
  endtask

  task automatic test_store;
    int n = 0;
    set_instr(7'b0100011, 3'b010, 7'b0000000);
    push(1, 0, 0, x_fetch(1, 3'b001));
    push(0, 0, 0, x_decode(3'b001));
    push(0, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 4'h0));
    for (int i = 0; i < 3; i++)
      push(i == 2, 0, 0, e(0, 0, 1, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 3'b001, 4'h0));
    push(0, 0, 0, x_fetch(0, 3'b001));
    while (sb.size() != 0) begin
      c = sb[0];
      @(posedge clk); #1;
      mem_ready = c.rdy; mdu_done = c.done; Taken = c.tk;
      @(negedge clk);
      c = sb.pop_front(); vectors++;
      if (w_obs !== c.exp) begin fails++; $display("FAIL sw cyc%0d got=%h want=%h", n, w_obs, c.exp); end
      n++;
    end
  endtask

  task automatic test_branch;
    set_instr(7'b1100011, 3'b000, 7'b0000000);
    for (int t = 1; t >= 0; t--) begin
      int n = 0;
      push(1, 0, 0, x_fetch(1, 3'b010));
      push(0, 0, 0, x_decode(3'b010));
      push(0, 0, 1'(t), e(0, 0, 0, 1'(t), 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 4'h1));
      push(0, 0, 0, x_fetch(0, 3'b010));
      while (sb.size() != 0) begin
        c = sb[0];
        @(posedge clk); #1;
        mem_ready = c.rdy; mdu_done = c.done; Taken = c.tk;
        @(negedge clk);
        c = sb.pop_front(); vectors++;
        if (w_obs !== c.exp) begin fails++; $display("FAIL beq_t%0d cyc%0d got=%h want=%h", t, n, w_obs, c.exp); end
        n++;
      end
    end
  endtask

  task automatic test_jumps;
    logic [6:0] ops[4] = '{7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    logic [2:0] imms[4] = '{3'b011, 3'b000, 3'b100, 3'b100};
    vec_t mids[4];
    mids[0] = e(0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b011, 4'h0);
    mids[1] = e(0, 0, 0, 1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01, 3'b000, 4'h0);
    mids[2] = e(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 3'b100, 4'h0);
    mids[3] = e(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b100, 4'h0);
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      set_instr(ops[k], 3'b000, 7'b0000000);
      push(1, 0, 0, x_fetch(1, imms[k]));
      push(0, 0, 0, x_decode(imms[k]));
      push(0, 0, 0, mids[k]);
      push(0, 0, 0, x_aluwb(imms[k]));
      push(0, 0, 0, x_fetch(0, imms[k]));
      while (sb.size() != 0) begin
        c = sb[0];
        @(posedge clk); #1;
        mem_ready = c.rdy; mdu_done = c.done; Taken = c.tk;
        @(negedge clk);
        c = sb.pop_front(); vectors++;
        if (w_obs !== c.exp) begin fails++; $display("FAIL jump%0d cyc%0d got=%h want=%h", k, n, w_obs, c.exp); end
        n++;
      end
    end
  endtask

  task automatic test_mul;
    int n = 0;
    set_instr(7'b0110011, 3'b000, 7'b0000001);
    push(1, 0, 0, x_fetch(1, 3'b000));
    push(0, 0, 0, x_decode(3'b000));
    for (int i = 0; i < 6; i++)
      push(0, i == 5, 0, e(0, i == 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0));
    push(0, 0, 0, x_aluwb(3'b000));
    push(1, 0, 0, x_fetch(1, 3'b000));
    push(0, 0, 0, x_decode(3'b000));
    push(0, 1, 0, e(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0));
    push(0, 0, 0, x_aluwb(3'b000));
    push(0, 0, 0, x_fetch(0, 3'b000));
    while (sb.size() != 0) begin
      c = sb[0];
      @(posedge clk); #1;
      mem_ready = c.rdy; mdu_done = c.done; Taken = c.tk;
      @(negedge clk);
      c = sb.pop_front(); vectors++;
      if (w_obs !== c.exp) begin fails++; $display("FAIL mul cyc%0d got=%h want=%h", n, w_obs, c.exp); end
      n++;
    end
    vectors++;
    if (w_obs0 !== e(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0)) begin
      fails++; $display("FAIL mul_no_mext got=%h want=%h", w_obs0,
                        e(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0));
    end
  endtask

  task automatic test_illegal;
    int n = 0;
    set_instr(7'b0000000, 3'b000, 7'b0000000);
    push(1, 0, 0, x_fetch(1, 3'b000));
    push(1, 0, 0, x_decode(3'b000));
    repeat (3) push(1, 1, 1, e(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0));
    while (sb.size() != 0) begin
      c = sb[0];
      @(posedge clk); #1;
      mem_ready = c.rdy; mdu_done = c.done; Taken = c.tk;
      @(negedge clk);
      c = sb.pop_front(); vectors++;
      if (w_obs !== c.exp) begin fails++; $display("FAIL illegal cyc%0d got=%h want=%h", n, w_obs, c.exp); end
      n++;
    end
    #2 rst = 1'b0;
    #1 vectors++;
    if (w_obs !== x_quiet(3'b000)) begin
      fails++; $display("FAIL illegal_clear got=%h want=%h", w_obs, x_quiet(3'b000));
    end
    @(posedge clk); #1 rst = 1'b1; mem_ready = 1'b0; mdu_done = 1'b0; Taken = 1'b0;
    @(negedge clk);
    vectors++;
    if (w_obs !== x_fetch(0, 3'b000)) begin
      fails++; $display("FAIL illegal_restart got=%h want=%h", w_obs, x_fetch(0, 3'b000));
    end
  endtask

  task automatic test_reset_mid_write;
    int n = 0;
    set_instr(7'b0100011, 3'b010, 7'b0000000);
    push(1, 0, 0, x_fetch(1, 3'b001));
    push(0, 0, 0, x_decode(3'b001));
    push(0, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 4'h0));
    push(0, 0, 0, e(0, 0, 1, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 3'b001, 4'h0));
    while (sb.size() != 0) begin
      c = sb[0];
      @(posedge clk); #1;
      mem_ready = c.rdy; mdu_done = c.done; Taken = c.tk;
      @(negedge clk);
      c = sb.pop_front(); vectors++;
      if (w_obs !== c.exp) begin fails++; $display("FAIL sw_rst cyc%0d got=%h want=%h", n, w_obs, c.exp); end
      n++;
    end
    #2 rst = 1'b0;
    #1 vectors++;
    if (w_obs !== x_quiet(3'b001)) begin
      fails++; $display("FAIL async_rst_write got=%h want=%h", w_obs, x_quiet(3'b001));
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (w_obs !== x_fetch(0, 3'b001)) begin
      fails++; $display("FAIL async_rst_restart got=%h want=%h", w_obs, x_fetch(0, 3'b001));
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_alu_ops;
    test_load_wait;
    test_store;
    test_branch;
    test_jumps;
    test_mul;
    test_illegal;
    test_reset_mid_write;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
